// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NUM_REQ requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int BUSY_TMO  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]       TMO_LAST  = 4'(BUSY_TMO - 1);
  localparam logic [7:0]       BURST_CAP = 8'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 err_q, err_d;
  logic                 lastflag_q, lastflag_d;
  logic [7:0]           burst_q, burst_d;
  logic [3:0]           tmo_q, tmo_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  // Search upward from the previous owner so every requester gets a turn.
  always_comb begin : rr_pick
    int cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_valid && req[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    lastflag_d = lastflag_q;
    burst_d    = burst_q;
    tmo_d      = tmo_q;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          idx_d   = pick_idx;
          grant_d = ONE_HOT0 << pick_idx;
          burst_d = '0;
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        tx_start_d = 1'b1;
        tx_data_d  = req_data[{idx_q, 3'b000} +: 8];
        ack_d      = ONE_HOT0 << idx_q;
        lastflag_d = req_last[idx_q];
        burst_d    = burst_q + 8'd1;
        tmo_d      = '0;
        state_d    = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // The byte is abandoned; the owner loses its lock.
          err_d   = 1'b1;
          grant_d = '0;
          state_d = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (!lastflag_q && req[idx_q] && (burst_q < BURST_CAP)) begin
            state_d = ST_LAUNCH;
          end else begin
            grant_d = '0;
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        last_d  = idx_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= LAST_RST;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      err_q      <= 1'b0;
      lastflag_q <= 1'b0;
      burst_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      lastflag_q <= lastflag_d;
      burst_q    <= burst_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int MB  = 3;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req_last, ack, grant;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_busy, err;
  logic [7:0]     tx_data;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .BUSY_TMO(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    logic [7:0] d;
    bit         ack_ok;
    int         gap;
  } launch_t;

  logic [8:0]   rq [N][$];
  launch_t      obs [$];
  int           exp_r [$];
  logic [7:0]   exp_d [$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           stray_ack = 0;
  int           bcnt = 0;
  int           frame = 6;
  int           fall_cyc = -100;
  bit           busy_en = 1'b1;
  logic [N-1:0] pend_ack = '0;
  int           model_last = N - 1;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        e = rq[i][0];
        req[i] = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One clock: sample outputs on the falling edge, then play requesters and uart_tx.
  task automatic tick();
    launch_t l;
    int g;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pend_ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    end
    pend_ack = ack;
    if (tx_start) begin
      g = -1;
      for (int i = 0; i < N; i++) if (grant[i]) g = i;
      l.r = g;
      l.d = tx_data;
      l.ack_ok = (ack === grant) && $onehot(grant);
      l.gap = cyc - fall_cyc;
      obs.push_back(l);
    end else if (ack !== '0) begin
      stray_ack++;
    end
    if (tx_start && busy_en) begin
      bcnt = frame;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) fall_cyc = cyc;
    end
    tx_busy = (bcnt != 0);
    drive();
  endtask

  // Reference: message-level replay of round-robin, lock and burst-cap rules.
  task automatic prep();
    logic [8:0] m [N][$];
    logic [8:0] e;
    int cap, win, cnt, c;
    for (int i = 0; i < N; i++) m[i] = rq[i];
    exp_r.delete();
    exp_d.delete();
    obs.delete();
    cap = busy_en ? MB : 1;
    while (1) begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        c = (model_last + k) % N;
        if (win < 0 && m[c].size() != 0) win = c;
      end
      if (win < 0) break;
      cnt = 0;
      do begin
        e = m[win].pop_front();
        exp_r.push_back(win);
        exp_d.push_back(e[7:0]);
        cnt++;
      end while (!e[8] && m[win].size() != 0 && cnt < cap);
      model_last = win;
    end
    drive();
  endtask

  task automatic finish_test(input string name);
    int guard, quiet;
    bit empty;
    guard = 0;
    quiet = 0;
    while (quiet < 3 && guard < 4000) begin
      tick();
      guard++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) empty = 1'b0;
      if (empty && bcnt == 0 && grant == '0 && !tx_start) quiet++;
      else quiet = 0;
    end
    check($sformatf("%s drained", name), 32'(guard < 4000), 32'd1);
    check($sformatf("%s count", name), obs.size(), exp_r.size());
    for (int j = 0; j < exp_r.size() && j < obs.size(); j++) begin
      check($sformatf("%s r[%0d]", name, j), obs[j].r, exp_r[j]);
      check($sformatf("%s d[%0d]", name, j), 32'(obs[j].d), 32'(exp_d[j]));
      check($sformatf("%s ack[%0d]", name, j), 32'(obs[j].ack_ok), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive();
    tick();
    tick();
    while (bcnt != 0) tick();
    rst_n = 1'b1;
    model_last = N - 1;
    obs.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rr_exp [6];
    int bu_exp [6];
    int w, nmsg, len;
    rr_exp = '{0, 1, 3, 0, 1, 3};
    bu_exp = '{0, 0, 0, 1, 0, 0};

    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    repeat (3) tick();
    check("rst ack", 32'(ack), 32'd0);
    check("rst grant", 32'(grant), 32'd0);
    check("rst tx_start", 32'(tx_start), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'h00);
    check("rst err", 32'(err), 32'd0);
    rst_n = 1'b1;
    model_last = N - 1;

    rq[2].push_back({1'b1, 8'hA5});
    prep();
    tick();
    check("single grant", 32'(grant), 32'b0100);
    check("single no early start", 32'(tx_start), 32'd0);
    tick();
    check("single tx_start", 32'(tx_start), 32'd1);
    check("single tx_data", 32'(tx_data), 32'hA5);
    check("single ack", 32'(ack), 32'b0100);
    finish_test("single");
    check("single released", 32'(grant), 32'd0);

    do_reset();
    for (int k = 0; k < 2; k++) begin
      rq[0].push_back({1'b1, 8'(8'h00 + k)});
      rq[1].push_back({1'b1, 8'(8'h10 + k)});
      rq[3].push_back({1'b1, 8'(8'h30 + k)});
    end
    prep();
    finish_test("rr");
    for (int j = 0; j < 6 && j < obs.size(); j++)
      check($sformatf("rr order[%0d]", j), obs[j].r, rr_exp[j]);

    do_reset();
    rq[0].push_back({1'b1, 8'h55});
    prep();
    finish_test("warm");
    rq[1].push_back({1'b0, 8'h10});
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b1, 8'h12});
    rq[0].push_back({1'b1, 8'h77});
    prep();
    finish_test("locked");
    if (obs.size() == 4) begin
      check("locked gap1", obs[1].gap, 2);
      check("locked gap2", obs[2].gap, 2);
      check("locked arb gap", obs[3].gap, 4);
      check("locked r0 last", obs[3].r, 0);
    end

    do_reset();
    for (int k = 0; k < 5; k++) rq[0].push_back({1'b0, 8'(8'h20 + k)});
    rq[1].push_back({1'b1, 8'h99});
    prep();
    finish_test("burst");
    for (int j = 0; j < 6 && j < obs.size(); j++)
      check($sformatf("burst order[%0d]", j), obs[j].r, bu_exp[j]);
    check("burst err", 32'(err), 32'd0);

    do_reset();
    busy_en = 1'b0;
    rq[1].push_back({1'b1, 8'h31});
    rq[2].push_back({1'b1, 8'h32});
    prep();
    w = 0;
    while (!tx_start && w < 20) begin
      tick();
      w++;
    end
    check("tmo start seen", 32'(w < 20), 32'd1);
    repeat (TMO - 1) tick();
    check("tmo err early", 32'(err), 32'd0);
    tick();
    check("tmo err set", 32'(err), 32'd1);
    finish_test("tmo");
    check("tmo err sticky", 32'(err), 32'd1);
    busy_en = 1'b1;

    for (int k = 0; k < 4; k++) rq[1].push_back({1'b0, 8'(8'h60 + k)});
    prep();
    w = 0;
    while (!tx_start && w < 20) begin
      tick();
      w++;
    end
    repeat (3) tick();
    check("midrst in frame", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive();
    tick();
    check("midrst grant", 32'(grant), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    check("midrst tx_start", 32'(tx_start), 32'd0);
    while (bcnt != 0) tick();
    tick();
    rst_n = 1'b1;
    model_last = N - 1;
    rq[0].push_back({1'b1, 8'h40});
    rq[3].push_back({1'b1, 8'h43});
    prep();
    finish_test("post rst");
    if (obs.size() > 0) check("post rst first", obs[0].r, 0);

    for (int round = 0; round < 5; round++) begin
      frame = $urandom_range(2, 8);
      for (int i = 0; i < N; i++) begin
        nmsg = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            rq[i].push_back({(b == len - 1) && ($urandom_range(0, 3) != 0), 8'($urandom)});
        end
      end
      prep();
      finish_test($sformatf("rand%0d", round));
    end

    check("stray ack", stray_ack, 0);
    check("final err", 32'(err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` byte transmitter between `NUM_REQ` independent requesters, such as a command responder, a status reporter and a debug dump. Requesters are served round-robin. A requester can lock the transmitter for a multi-byte message until it flags the last byte. A burst cap prevents any one requester from starving the others. The block sits between the requester logic and the single `uart_tx` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum bytes sent per grant before a forced release, 1..255.
- `BUSY_TMO`, 4: cycles allowed for `tx_busy` to rise after `tx_start`, 2..15.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  NUM_REQ  per-requester byte-valid; held high with stable data until acknowledged.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  qualifies `req`: this byte ends the requester's message.
- `ack`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- `grant`  out  NUM_REQ  one-hot; requester that currently owns the transmitter.
- `tx_start`  out  1  one-cycle launch pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; registered, stable from `tx_start` until the next launch.
- `tx_busy`  in  1  `uart_tx` busy, high while a frame is shifting out.
- `err`  out  1  sticky: `tx_busy` failed to rise within `BUSY_TMO` cycles. Cleared only by reset.

## Operation
- The FSM has five states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE.
- **IDLE**
  - `grant`=0.
  - If any `req` is high, pick the first set bit searching upward from `last+1`, wrapping modulo `NUM_REQ`.
  - Register the winner as `idx`, set `grant[idx]`, clear the burst counter, and go to LAUNCH.
- **LAUNCH** (exactly one cycle)
  - `tx_start`=1, `tx_data`<=`req_data[idx]`, `ack[idx]`=1.
  - Latch `lastflag`<=`req_last[idx]`, increment the burst counter, and go to WAIT_BUSY.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise count cycles. When the count reaches `BUSY_TMO`, set `err` and go to RELEASE; the byte is treated as lost.
- **WAIT_DONE**
  - Leave only when `tx_busy`=0.
  - Go to LAUNCH (same `idx`) if all of the following hold: `lastflag`=0, `req[idx]`=1, and burst counter < `MAX_BURST`.
  - Otherwise go to RELEASE.
- **RELEASE** (one cycle)
  - `last`<=`idx`, `grant`=0, go to IDLE.
- Lock rule: a message stays locked only while its owner keeps `req` high at each byte boundary. A dropped `req` releases the lock, with no wait.
- Forced release at `MAX_BURST` does not report an error. The requester simply re-arbitrates, and its remaining bytes go in its next grant.
- `req` from non-granted requesters is ignored outside IDLE. Those requesters keep their `req` high and are not acknowledged.
- Requests arriving in the RELEASE cycle are seen in the following IDLE cycle.
- At most one `ack` bit is high in any cycle, and only in LAUNCH.

## Timing
- **Reset** (`rst_n`=0 at a rising edge):
  - State=IDLE.
  - `ack`=0, `grant`=0, `tx_start`=0, `tx_data`=8'h00, `err`=0.
  - `last`=`NUM_REQ-1`, so requester 0 wins first.
  - Burst and timeout counters=0.
- Reset mid-frame is allowed. Outputs return to reset values on the next edge; any frame already in `uart_tx` completes on its own.
- **Latency:**
  - `req` rises in IDLE at edge t: `grant` at t+1, `tx_start`/`ack` at t+2.
  - Back-to-back locked bytes: `tx_start` one cycle after `tx_busy` falls.
  - Arbitration gap between owners: 3 cycles from `tx_busy` low to the next `tx_start` (RELEASE, IDLE, LAUNCH).
- **Handshake:** a requester may change `req_data`/`req_last` or drop `req` on the cycle after `ack`.
- **Width rules:**
  - `idx`/`last`: clog2(`NUM_REQ`) bits.
  - Burst counter: 8 bits; compared with `MAX_BURST` at the WAIT_DONE exit.
  - Timeout counter: 4 bits.
- All outputs are registered.

## Test plan
- **Single byte:** only `req[2]` with 0xA5, `req_last`=1.
  - `grant`=4'b0100 one cycle later; `tx_start` with `tx_data`=0xA5 and `ack[2]` on the next cycle.
  - `grant`=0 after `tx_busy` falls.
- **Round-robin:** `req[0]`, `req[1]` and `req[3]` held continuously, each with `req_last`=1. Grant order must be 0, 1, 3, 0, 1, 3.
- **Locked message:** `req[1]` sends 0x10, 0x11, 0x12 with `req_last`=1 on 0x12 only, while `req[0]` is also pending.
  - All three bytes go out before `grant[0]`.
  - Each `tx_start` occurs one cycle after `tx_busy` falls.
- **Burst cap:** `MAX_BURST`=2, `req[0]` streams 5 bytes with `req_last`=0, `req[1]` is pending.
  - Output order: r0, r0, r1, r0, r0, r0.
  - `err` stays 0.
- **Timeout:** the `uart_tx` model never raises `tx_busy`.
  - `err`=1 exactly `BUSY_TMO` cycles after `tx_start`; the next requester is then served.
  - `err` stays high until `rst_n`=0.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT_DONE.
  - The next edge gives `grant`=0, `err`=0, `tx_start`=0.
  - After release, requester 0 wins over a simultaneous requester 3.
